// File: rtl/mem_stage.sv
// Memory stage: resolves redirects, runs the dmem access and
// registers the retire bundle handed to writeback.
module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_inst,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_pc4,
  input  logic [XLEN-1:0] i_result,
  input  logic            i_eq,
  input  logic            i_slt,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_jump,
  input  logic            i_branch_eq,
  input  logic            i_branch_lt,
  input  logic            i_mem_read,
  input  logic            i_mem_write,
  input  logic            i_mem_to_reg,
  input  logic            i_reg_write,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd_waddr,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic            o_dmem_ren,
  output logic            o_dmem_wen,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_mask,
  input  logic            i_dmem_ready,
  input  logic            i_dmem_valid,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_valid,
  output logic [XLEN-1:0] o_wb_inst,
  output logic [XLEN-1:0] o_wb_pc,
  output logic [XLEN-1:0] o_wb_next_pc,
  output logic [4:0]      o_wb_rd_waddr,
  output logic [XLEN-1:0] o_wb_rd_wdata,
  output logic            o_wb_trap
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  typedef struct packed {
    logic            load;
    logic            use_mem;
    logic [2:0]      f3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      mask;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] rd_data;
  } cap_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] next_pc;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
    logic            trap;
  } wb_t;

  state_e state_q, state_d;
  cap_t   cap_q, cap_d;
  wb_t    wb_q, wb_d;

  logic            accept, taken, tgt_bad;
  logic            mem_op, size_ok, align_ok;
  logic            trap, mem_go;
  logic [1:0]      off;
  logic [3:0]      base;
  logic [4:0]      rd_eff;
  logic [XLEN-1:0] next_pc, alu_data;
  logic [XLEN-1:0] shifted, ld_data;

  assign off     = i_result[1:0];
  assign mem_op  = i_mem_read | i_mem_write;
  assign taken   = i_jump
                 | (i_branch_eq & i_eq)
                 | (i_branch_lt & i_slt);
  assign tgt_bad = taken & (i_target[1:0] != 2'b00);
  assign accept  = i_valid & o_ready & i_rst_n;

  assign size_ok = i_mem_read
    ? (i_funct3 inside {3'b000, 3'b001, 3'b010,
                        3'b100, 3'b101})
    : (i_funct3 inside {3'b000, 3'b001, 3'b010});

  always_comb begin
    base     = 4'b0001;
    align_ok = 1'b1;
    unique case (i_funct3[1:0])
      2'b01: begin
        base     = 4'b0011;
        align_ok = ~off[0];
      end
      2'b10: begin
        base     = 4'b1111;
        align_ok = (off == 2'b00);
      end
      default: ;
    endcase
  end

  assign trap   = tgt_bad
                | (mem_op & ~(size_ok & align_ok));
  assign mem_go = mem_op & ~trap;

  assign rd_eff = (i_reg_write & ~trap
                   & (i_rd_waddr != 5'd0))
                ? i_rd_waddr : 5'd0;

  assign next_pc  = taken ? i_target : i_pc4;
  assign alu_data = i_jump ? i_pc4 : i_result;

  assign o_redirect    = accept & taken & ~tgt_bad;
  assign o_redirect_pc = o_redirect ? i_target : i_pc4;

  // Load lane extraction from the captured byte offset.
  assign shifted = i_dmem_rdata >> {cap_q.addr[1:0], 3'b000};

  always_comb begin
    unique case (cap_q.f3)
      3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {24'd0, shifted[7:0]};
      3'b101:  ld_data = {16'd0, shifted[15:0]};
      default: ld_data = shifted;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      wb_q    <= wb_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && mem_go) begin
          cap_d.load    = i_mem_read;
          cap_d.use_mem = i_mem_read & i_mem_to_reg;
          cap_d.f3      = i_funct3;
          cap_d.addr    = i_result;
          cap_d.wdata   = i_store_data << {off, 3'b000};
          cap_d.mask    = base << off;
          cap_d.inst    = i_inst;
          cap_d.pc      = i_pc;
          cap_d.next_pc = next_pc;
          cap_d.rd      = rd_eff;
          cap_d.rd_data = alu_data;
          state_d       = REQ;
        end else if (accept) begin
          wb_d = '{1'b1, i_inst, i_pc, next_pc,
                   rd_eff, alu_data, trap};
        end
      end
      REQ: begin
        if (i_dmem_ready && cap_q.load) begin
          state_d = RESP;
        end else if (i_dmem_ready) begin
          state_d = IDLE;
          wb_d = '{1'b1, cap_q.inst, cap_q.pc,
                   cap_q.next_pc, cap_q.rd,
                   cap_q.rd_data, 1'b0};
        end
      end
      RESP: begin
        if (i_dmem_valid) begin
          state_d = IDLE;
          wb_d = '{1'b1, cap_q.inst, cap_q.pc,
                   cap_q.next_pc, cap_q.rd,
                   cap_q.use_mem ? ld_data
                                 : cap_q.rd_data,
                   1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready      = 1'b0;
    o_dmem_ren   = 1'b0;
    o_dmem_wen   = 1'b0;
    o_dmem_addr  = '0;
    o_dmem_wdata = '0;
    o_dmem_mask  = '0;
    unique case (state_q)
      IDLE: o_ready = 1'b1;
      REQ: begin
        o_dmem_ren   = cap_q.load;
        o_dmem_wen   = ~cap_q.load;
        o_dmem_addr  = {cap_q.addr[XLEN-1:2], 2'b00};
        o_dmem_wdata = cap_q.wdata;
        o_dmem_mask  = cap_q.mask;
      end
      default: ;
    endcase
  end

  assign o_wb_valid    = wb_q.valid;
  assign o_wb_inst     = wb_q.inst;
  assign o_wb_pc       = wb_q.pc;
  assign o_wb_next_pc  = wb_q.next_pc;
  assign o_wb_rd_waddr = wb_q.rd;
  assign o_wb_rd_wdata = wb_q.data;
  assign o_wb_trap     = wb_q.trap;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the 5-stage hart. Sits between execute and writeback.
- Consumes the execute-stage result bundle, resolves branch/jump redirect and performs the data access over a request/ready/valid dmem port.
- Aligns and sign/zero-extends loads, positions store data and byte masks, and flags misalignment traps.
- Registers the retire bundle handed to writeback; stalls execute while a memory access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  global clock
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  execute bundle valid
- o_ready  out  1  stage can accept the bundle this cycle
- i_inst  in  32  instruction word
- i_pc  in  32  instruction PC
- i_pc4  in  32  i_pc+4
- i_result  in  32  ALU result / effective address
- i_eq, i_slt  in  1 each  ALU compare flags
- i_target  in  32  branch/jump target
- i_jump, i_branch_eq, i_branch_lt  in  1 each  control-flow type
- i_mem_read, i_mem_write, i_mem_to_reg, i_reg_write  in  1 each  control bits
- i_funct3  in  3  access size/sign
- i_store_data  in  32  rs2 value
- i_rd_waddr  in  5  destination register
- o_redirect  out  1  taken branch/jump accepted this cycle
- o_redirect_pc  out  32  next fetch PC
- o_dmem_addr  out  32  word-aligned address
- o_dmem_ren, o_dmem_wen  out  1 each  read/write request; never both high
- o_dmem_wdata  out  32  lane-shifted store data
- o_dmem_mask  out  4  byte lanes
- i_dmem_ready  in  1  request accepted
- i_dmem_valid  in  1  read data valid
- i_dmem_rdata  in  32  read word
- o_wb_valid  out  1  one-cycle pulse per completed instruction
- o_wb_inst, o_wb_pc, o_wb_next_pc  out  32 each  retire info
- o_wb_rd_waddr  out  5  destination register; 0 if no write
- o_wb_rd_wdata  out  32  writeback data
- o_wb_trap  out  1  instruction trapped

Behaviour:
- Reset (async, i_rst_n low):
  - FSM goes to IDLE.
  - All o_wb_* and o_dmem_* outputs are 0; o_redirect is 0.
  - No bundle is accepted while reset is asserted.
  - Reset during REQ/RESP abandons the access; no o_wb_valid is produced for it.
- o_ready = (state == IDLE). Accept = i_valid & o_ready.
- Taken condition: i_jump | (i_branch_eq & i_eq) | (i_branch_lt & i_slt).
- Redirect (combinational on accept):
  - Taken and i_target[1:0]==0: o_redirect=1, o_redirect_pc=i_target.
  - Otherwise o_redirect=0 and o_redirect_pc=i_pc4.
  - Taken with i_target[1:0]!=0: trap and no redirect; o_wb_next_pc=i_target.
- Size decode:
  - Loads: funct3 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Stores: funct3 000 sb, 001 sh, 010 sw.
  - Any other funct3 with a memory op traps.
- Alignment: halfword requires addr[0]==0; word requires addr[1:0]==0; otherwise trap.
- A trapping instruction never issues a dmem request.
- Mask and data:
  - Mask = 0001, 0011 or 1111 shifted left by addr[1:0] for byte, half or word.
  - o_dmem_addr = {addr[31:2], 2'b00}.
  - wdata = i_store_data << (8*addr[1:0]).
  - Load data = (rdata >> 8*addr[1:0]), then sign- or zero-extended by funct3.
- FSM states: IDLE, REQ, RESP.
  - IDLE, accept of a non-memory or trapping op: the W register loads on the same edge (1-cycle latency); stay in IDLE.
  - IDLE, accept of a legal memory op: capture the bundle; go to REQ.
  - REQ: drive ren/wen, addr, mask and wdata from the captured bundle, held stable until i_dmem_ready.
  - REQ, i_dmem_ready on a store: load the W register; go to IDLE.
  - REQ, i_dmem_ready on a load: go to RESP.
  - RESP: ren is 0; wait for i_dmem_valid, then load the W register with the extracted data; go to IDLE.
- i_dmem_valid outside RESP is ignored. i_dmem_ready and i_dmem_valid may both arrive one cycle after the request (minimum load latency is 2 cycles in REQ/RESP).
- rd data select: jump → pc4; load → extracted data; otherwise i_result.
- o_wb_rd_waddr = i_rd_waddr only if i_reg_write, no trap, and rd != 0; else 0.
- o_wb_valid is high for exactly one cycle per completed instruction. Other o_wb_* outputs hold their last value otherwise.
- Writeback never back-pressures this stage.

Test Plan:
- Non-memory op: addi with result 0x5, rd=3 → o_wb_valid next cycle, rd_waddr=3, rd_wdata=0x5, o_ready stays 1.
- lb at address 0x1003, memory word 0x80xxxxxx, ready after 2 cycles and valid after 1 more → mask 1000, addr 0x1000, rd_wdata=0xFFFFFF80; o_ready low until the retire edge.
- sh of 0x1234ABCD at address 0x2002 → wen, mask 1100, wdata 0xABCD0000; o_wb_valid on the ready edge; rd_waddr=0.
- lw at address 0x3001 → no ren, o_wb_trap=1, rd_waddr=0, retires in 1 cycle.
- beq taken with target 0x40 → o_redirect=1, pc 0x40; jal to 0x42 → trap, no redirect, rd_waddr=0, next_pc 0x42.
- Reset asserted while in RESP → outputs 0, state IDLE, no o_wb_valid pulse; the next lw completes normally.
